// File: rtl/reg_file_sb.sv
// ============================================================================
// Module      : reg_file_sb
// Description : Parametrised 2-read/1-write register file with a per-register
//               busy scoreboard, optional zero register and write bypass.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_file_sb #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    output logic              OUT1BUSY,
    output logic              OUT2BUSY,
    input  logic              RESERVE,
    input  logic [ADDR_W-1:0] RESADDRESS,
    output logic              RES_STALL,
    output logic [ADDR_W:0]   BUSYCOUNT
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    // An address is usable only if it maps to real storage that is not the zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < c_DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [ADDR_W:0]  count_q;
    logic [ADDR_W:0]  count_d;

    logic wr_ok;
    logic wr_busy;
    logic res_busy;
    logic res_ok;

    always_comb begin : p_lookup
        wr_busy  = 1'b0;
        res_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (INADDRESS == ADDR_W'(i))  wr_busy  = busy_q[i];
            if (RESADDRESS == ADDR_W'(i)) res_busy = busy_q[i];
        end
    end

    assign wr_ok     = WRITE & addr_ok(INADDRESS);
    assign RES_STALL = RESERVE & addr_ok(RESADDRESS) & res_busy;
    assign res_ok    = RESERVE & addr_ok(RESADDRESS) & ~res_busy;

    // Reservation is applied after the write so it wins on a same-address collision.
    always_comb begin : p_next
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && (INADDRESS == ADDR_W'(i))) begin
                regs_d[i] = IN;
                busy_d[i] = 1'b0;
            end
            if (res_ok && (RESADDRESS == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        // An accepted reservation always targets a clear bit, so a same-address
        // write never sees wr_busy set and the two never cancel incorrectly.
        count_d = count_q + (ADDR_W+1)'(res_ok) - (ADDR_W+1)'(wr_ok & wr_busy);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    always_comb begin : p_read
        OUT1     = '0;
        OUT2     = '0;
        OUT1BUSY = 1'b0;
        OUT2BUSY = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (OUT1ADDRESS == ADDR_W'(i)) begin
                OUT1     = regs_q[i];
                OUT1BUSY = busy_q[i];
            end
            if (OUT2ADDRESS == ADDR_W'(i)) begin
                OUT2     = regs_q[i];
                OUT2BUSY = busy_q[i];
            end
        end
        if (!addr_ok(OUT1ADDRESS)) begin
            OUT1     = '0;
            OUT1BUSY = 1'b0;
        end
        if (!addr_ok(OUT2ADDRESS)) begin
            OUT2     = '0;
            OUT2BUSY = 1'b0;
        end
        if ((BYPASS != 0) && wr_ok && (INADDRESS == OUT1ADDRESS)) begin
            OUT1     = IN;
            OUT1BUSY = 1'b0;
        end
        if ((BYPASS != 0) && wr_ok && (INADDRESS == OUT2ADDRESS)) begin
            OUT2     = IN;
            OUT2BUSY = 1'b0;
        end
    end

    assign BUSYCOUNT = count_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Directed vector bench for reg_file_sb in three configurations.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared stimulus for the 8x8 instances (A: bypass, B: no bypass + zero reg)
    logic       RESET;
    logic [7:0] IN;
    logic [2:0] INADDRESS, OUT1ADDRESS, OUT2ADDRESS, RESADDRESS;
    logic       WRITE, RESERVE;

    logic [7:0] a_out1, a_out2, b_out1, b_out2;
    logic       a_b1, a_b2, a_st, b_b1, b_b2, b_st;
    logic [3:0] a_cnt, b_cnt;

    // Stimulus for the 16x12 instance
    logic [15:0] c_in;
    logic [3:0]  c_wa, c_a1, c_a2, c_ra;
    logic        c_wr, c_res;
    logic [15:0] c_out1, c_out2;
    logic        c_b1, c_b2, c_st;
    logic [4:0]  c_cnt;

    reg_file_sb #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_a (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(a_out1), .OUT2(a_out2), .OUT1BUSY(a_b1), .OUT2BUSY(a_b2),
        .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .RES_STALL(a_st), .BUSYCOUNT(a_cnt)
    );

    reg_file_sb #(.WIDTH(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_b (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
        .OUT1(b_out1), .OUT2(b_out2), .OUT1BUSY(b_b1), .OUT2BUSY(b_b2),
        .RESERVE(RESERVE), .RESADDRESS(RESADDRESS), .RES_STALL(b_st), .BUSYCOUNT(b_cnt)
    );

    reg_file_sb #(.WIDTH(16), .DEPTH(12), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u_c (
        .CLK(CLK), .RESET(RESET), .IN(c_in), .INADDRESS(c_wa), .WRITE(c_wr),
        .OUT1ADDRESS(c_a1), .OUT2ADDRESS(c_a2),
        .OUT1(c_out1), .OUT2(c_out2), .OUT1BUSY(c_b1), .OUT2BUSY(c_b2),
        .RESERVE(c_res), .RESADDRESS(c_ra), .RES_STALL(c_st), .BUSYCOUNT(c_cnt)
    );

    typedef struct {
        logic       wr;
        logic [2:0] wa;
        logic [7:0] din;
        logic [2:0] a1;
        logic [2:0] a2;
        logic       res;
        logic [2:0] ra;
        logic [7:0] o1;
        logic [7:0] o2;
        logic       b1;
        logic       b2;
        logic       st;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [14];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input int wr, input int wa, input int din, input int a1,
                                input int a2, input int res, input int ra, input int o1,
                                input int o2, input int b1, input int b2, input int st,
                                input int cnt);
        vec_t v;
        v.wr = wr[0];   v.wa = wa[2:0];  v.din = din[7:0];
        v.a1 = a1[2:0]; v.a2 = a2[2:0];  v.res = res[0];   v.ra = ra[2:0];
        v.o1 = o1[7:0]; v.o2 = o2[7:0];  v.b1 = b1[0];     v.b2 = b2[0];
        v.st = st[0];   v.cnt = cnt[3:0];
        return v;
    endfunction

    function automatic logic [15:0] pat(input int i);
        return 16'(32'h1111 * (i + 1));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_a();
        WRITE = 1'b0; RESERVE = 1'b0; IN = 8'h00;
        INADDRESS = 3'd0; RESADDRESS = 3'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // wr wa din  a1 a2 res ra   o1  o2  b1 b2 st cnt
        tbl[0]  = mk(0, 0, 'h00, 0, 7, 0, 0, 'h00, 'h00, 0, 0, 0, 0);
        tbl[1]  = mk(1, 2, 'hA5, 2, 3, 0, 0, 'hA5, 'h00, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 'h00, 2, 2, 0, 0, 'hA5, 'hA5, 0, 0, 0, 0);
        tbl[3]  = mk(1, 4, 'h3C, 4, 2, 0, 0, 'h3C, 'hA5, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 'h00, 5, 4, 1, 5, 'h00, 'h3C, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 'h00, 5, 4, 1, 5, 'h00, 'h3C, 1, 0, 1, 1);
        tbl[6]  = mk(1, 5, 'h11, 5, 5, 0, 0, 'h11, 'h11, 0, 0, 0, 1);
        tbl[7]  = mk(0, 0, 'h00, 5, 6, 1, 6, 'h11, 'h00, 0, 0, 0, 0);
        tbl[8]  = mk(1, 6, 'h66, 6, 7, 1, 7, 'h66, 'h00, 0, 0, 0, 1);
        tbl[9]  = mk(1, 1, 'h77, 6, 7, 1, 1, 'h66, 'h00, 0, 1, 0, 1);
        tbl[10] = mk(1, 7, 'h99, 1, 7, 1, 7, 'h77, 'h99, 1, 0, 1, 2);
        tbl[11] = mk(0, 0, 'h00, 7, 1, 0, 0, 'h99, 'h77, 0, 1, 0, 1);
        tbl[12] = mk(1, 1, 'h12, 1, 0, 0, 0, 'h12, 'h00, 0, 0, 0, 1);
        tbl[13] = mk(0, 0, 'h00, 1, 0, 0, 0, 'h12, 'h00, 0, 0, 0, 0);

        RESET = 1'b1;
        idle_a();
        OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
        c_in = 16'h0; c_wa = 4'd0; c_a1 = 4'd0; c_a2 = 4'd0; c_ra = 4'd0;
        c_wr = 1'b0; c_res = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // Table: inputs applied after negedge, outputs checked before next posedge
        for (int k = 0; k < 14; k++) begin
            WRITE = tbl[k].wr; INADDRESS = tbl[k].wa; IN = tbl[k].din;
            OUT1ADDRESS = tbl[k].a1; OUT2ADDRESS = tbl[k].a2;
            RESERVE = tbl[k].res; RESADDRESS = tbl[k].ra;
            #1;
            chk($sformatf("vec%0d", k),
                64'({a_out1, a_out2, a_b1, a_b2, a_st, a_cnt}),
                64'({tbl[k].o1, tbl[k].o2, tbl[k].b1, tbl[k].b2, tbl[k].st, tbl[k].cnt}));
            @(negedge CLK);
        end

        // Asynchronous reset between edges
        WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h5A;
        RESERVE = 1'b1; RESADDRESS = 3'd5;
        OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd5;
        @(negedge CLK);
        idle_a();
        #1;
        chk("pre_reset", 64'({a_out1, a_b2, a_cnt}), 64'({8'h5A, 1'b1, 4'd1}));
        #1 RESET = 1'b1;
        #1;
        chk("async_reset", 64'({a_out1, a_b2, a_cnt}), 64'({8'h00, 1'b0, 4'd0}));
        WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h77;
        RESERVE = 1'b1; RESADDRESS = 3'd5;
        @(negedge CLK);
        idle_a();
        RESET = 1'b0;
        #1;
        chk("write_in_reset", 64'({a_out1, a_b2, a_cnt}), 64'({8'h00, 1'b0, 4'd0}));

        // Instance B: no bypass, zero register
        @(negedge CLK);
        WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h10; OUT1ADDRESS = 3'd4;
        @(negedge CLK);
        IN = 8'h3C;
        #1;
        chk("nobypass_old", 64'(b_out1), 64'(8'h10));
        @(posedge CLK); #1;
        chk("nobypass_new", 64'(b_out1), 64'(8'h3C));
        @(negedge CLK);
        INADDRESS = 3'd0; IN = 8'hFF; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
        #1;
        chk("zero_wr_same", 64'({b_out1, a_out1}), 64'({8'h00, 8'hFF}));
        @(posedge CLK); #1;
        chk("zero_wr_after", 64'({b_out1, b_b1, a_out2}), 64'({8'h00, 1'b0, 8'hFF}));
        @(negedge CLK);
        idle_a();
        RESERVE = 1'b1; RESADDRESS = 3'd0;
        #1;
        chk("zero_res_stall", 64'(b_st), 64'(1'b0));
        @(negedge CLK);
        #1;
        chk("zero_res_again", 64'({b_st, b_b1, b_cnt}), 64'({1'b0, 1'b0, 4'd0}));
        @(negedge CLK);
        RESADDRESS = 3'd3;
        @(negedge CLK);
        RESERVE = 1'b0;
        WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h42; OUT1ADDRESS = 3'd3;
        #1;
        chk("b_busy_nobyp", 64'({b_out1, b_b1, b_cnt}), 64'({8'h00, 1'b1, 4'd1}));
        @(posedge CLK); #1;
        chk("b_busy_clear", 64'({b_out1, b_b1, b_cnt}), 64'({8'h42, 1'b0, 4'd0}));
        @(negedge CLK);
        idle_a();

        // Instance C: 16-bit, 12 registers, 4-bit addresses
        for (int i = 0; i < 12; i++) begin
            c_wr = 1'b1; c_wa = 4'(i); c_in = pat(i);
            @(negedge CLK);
        end
        c_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            c_a1 = 4'(i); c_a2 = 4'(11 - i);
            #1;
            chk($sformatf("c_read%0d", i), 64'({c_out1, c_out2}), 64'({pat(i), pat(11 - i)}));
            @(negedge CLK);
        end
        c_wr = 1'b1; c_wa = 4'd13; c_in = 16'hFFFF; c_a1 = 4'd13; c_a2 = 4'd12;
        #1;
        chk("c_oor_bypass", 64'({c_out1, c_b1, c_out2}), 64'({16'h0, 1'b0, 16'h0}));
        @(negedge CLK);
        c_wr = 1'b0;
        #1;
        chk("c_oor_read", 64'({c_out1, c_out2}), 64'({16'h0, 16'h0}));
        for (int i = 0; i < 12; i++) begin
            c_res = 1'b1; c_ra = 4'(i);
            @(negedge CLK);
        end
        c_ra = 4'd13; c_a1 = 4'd5; c_a2 = 4'd13;
        #1;
        chk("c_full", 64'({c_st, c_cnt, c_b1, c_b2}), 64'({1'b0, 5'd12, 1'b1, 1'b0}));
        @(negedge CLK);
        c_ra = 4'd3;
        #1;
        chk("c_full_stall", 64'({c_st, c_cnt}), 64'({1'b1, 5'd12}));
        @(negedge CLK);
        c_res = 1'b0;
        #1;
        chk("c_full_hold", 64'(c_cnt), 64'(5'd12));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
